// File: rtl/fft_frame_sequencer.sv
// CP stripper and FFT burst framer between the RX sample stream and the 64-point FFT input FIFO.
// Optional status outputs (err_count, max_occ) are built when FFT_FRAME_SEQ_STATUS_EN is defined.
module fft_frame_sequencer #(
  parameter int DATA    = 12,
  parameter int MEM     = 64,
  parameter int CP_LEN  = 16,
  parameter int FFT_LEN = 64,
  parameter int OW      = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [DATA-1:0] in_data,
  input  logic            sym_start,
  output logic            fifo_we,
  output logic [DATA-1:0] fifo_wdata,
  output logic            fifo_re,
  input  logic            fifo_valid,
  input  logic [DATA-1:0] fifo_rdata,
  input  logic            fft_ready,
  output logic            fft_start,
  output logic            fft_valid,
  output logic [DATA-1:0] fft_data,
  output logic            fft_last,
  output logic [OW-1:0]   sym_ready,
  output logic            overflow_err,
  output logic            sync_err,
  output logic [1:0]      dbg_wr_state,
  output logic [1:0]      dbg_rd_state
`ifdef FFT_FRAME_SEQ_STATUS_EN
  ,
  output logic [7:0]      err_count,
  output logic [OW-1:0]   max_occ
`endif
);

  // Handshakes: in_valid is a one-cycle strobe with no backpressure; fifo_re is a read request whose
  // data returns later, marked only by fifo_valid (latency unknown); fft_ready is sampled in R_IDLE only.
  typedef enum logic [1:0] {W_IDLE, W_CP, W_DATA} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_START, R_BURST, R_DRAIN} rd_state_e;

  wr_state_e wr_state_q, wr_state_d;
  rd_state_e rd_state_q, rd_state_d;

  logic [OW-1:0]   cp_cnt_q, cp_cnt_d;
  logic [OW-1:0]   wr_cnt_q, wr_cnt_d;
  logic [OW-1:0]   occ_q, occ_d;
  logic [OW-1:0]   sym_ready_q, sym_ready_d;
  logic [OW-1:0]   issued_q, issued_d;
  logic [OW-1:0]   beat_cnt_q, beat_cnt_d;
  logic            fifo_we_q;
  logic [DATA-1:0] fifo_wdata_q, fifo_wdata_d;
  logic            overflow_err_q, sync_err_q;

  logic data_take, data_last, drop, we_d, sync_d;

  // State registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_state_q <= W_IDLE;
      rd_state_q <= R_IDLE;
    end else begin
      wr_state_q <= wr_state_d;
      rd_state_q <= rd_state_d;
    end
  end

  always_comb begin : wr_next
    wr_state_d = wr_state_q;
    unique case (wr_state_q)
      W_IDLE:  if (in_valid && sym_start) wr_state_d = (CP_LEN == 1) ? W_DATA : W_CP;
      W_CP:    if (in_valid && !sym_start && cp_cnt_q == OW'(CP_LEN - 1)) wr_state_d = W_DATA;
      W_DATA:  if (data_last) wr_state_d = W_IDLE;
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_comb begin : wr_out
    data_take = (wr_state_q == W_DATA) && in_valid;
    data_last = data_take && (wr_cnt_q == OW'(FFT_LEN - 1));
    // A read in the same cycle frees a slot, so only a full FIFO with no read drops the sample.
    drop      = data_take && (occ_q == OW'(MEM)) && !fifo_re;
    we_d      = data_take && !drop;
    sync_d    = data_take && sym_start;
    cp_cnt_d  = cp_cnt_q;
    wr_cnt_d  = wr_cnt_q;
    unique case (wr_state_q)
      W_IDLE:  if (in_valid && sym_start) cp_cnt_d = OW'(1);
      W_CP:    if (in_valid) cp_cnt_d = sym_start ? OW'(1) : cp_cnt_q + OW'(1);
      W_DATA:  if (data_take) wr_cnt_d = data_last ? '0 : wr_cnt_q + OW'(1);
      default: ;
    endcase
  end

  always_comb begin : rd_next
    rd_state_d = rd_state_q;
    unique case (rd_state_q)
      R_IDLE:  if (sym_ready_q != '0 && fft_ready) rd_state_d = R_START;
      R_START: rd_state_d = R_BURST;
      R_BURST: begin
        if (fft_last) rd_state_d = R_IDLE;
        else if (issued_q == OW'(FFT_LEN)) rd_state_d = R_DRAIN;
      end
      R_DRAIN: if (fft_last) rd_state_d = R_IDLE;
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_comb begin : rd_out
    fft_start  = (rd_state_q == R_START);
    // occ counts a write as soon as it is decided; the one still in flight on fifo_we is not readable yet.
    fifo_re    = (rd_state_q == R_BURST) && (issued_q != OW'(FFT_LEN)) &&
                 (occ_q > {{(OW-1){1'b0}}, fifo_we_q});
    fft_valid  = fifo_valid && ((rd_state_q == R_BURST) || (rd_state_q == R_DRAIN));
    fft_last   = fft_valid && (beat_cnt_q == OW'(FFT_LEN - 1));
    issued_d   = issued_q;
    beat_cnt_d = beat_cnt_q;
    if (rd_state_q == R_START) begin
      issued_d   = '0;
      beat_cnt_d = '0;
    end else begin
      if (fifo_re)   issued_d   = issued_q + OW'(1);
      if (fft_valid) beat_cnt_d = fft_last ? '0 : beat_cnt_q + OW'(1);
    end
  end

  always_comb begin : shared_next
    occ_d        = occ_q + OW'(we_d) - OW'(fifo_re);
    sym_ready_d  = sym_ready_q + OW'(data_last) - OW'(fft_last);
    fifo_wdata_d = we_d ? in_data : fifo_wdata_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cp_cnt_q       <= '0;
      wr_cnt_q       <= '0;
      occ_q          <= '0;
      sym_ready_q    <= '0;
      issued_q       <= '0;
      beat_cnt_q     <= '0;
      fifo_we_q      <= 1'b0;
      fifo_wdata_q   <= '0;
      overflow_err_q <= 1'b0;
      sync_err_q     <= 1'b0;
    end else begin
      cp_cnt_q       <= cp_cnt_d;
      wr_cnt_q       <= wr_cnt_d;
      occ_q          <= occ_d;
      sym_ready_q    <= sym_ready_d;
      issued_q       <= issued_d;
      beat_cnt_q     <= beat_cnt_d;
      fifo_we_q      <= we_d;
      fifo_wdata_q   <= fifo_wdata_d;
      overflow_err_q <= drop;
      sync_err_q     <= sync_d;
    end
  end

  assign fifo_we      = fifo_we_q;
  assign fifo_wdata   = fifo_wdata_q;
  assign fft_data     = fifo_rdata;
  assign sym_ready    = sym_ready_q;
  assign overflow_err = overflow_err_q;
  assign sync_err     = sync_err_q;
  assign dbg_wr_state = wr_state_q;
  assign dbg_rd_state = rd_state_q;

`ifdef FFT_FRAME_SEQ_STATUS_EN
  logic [7:0]    err_count_q, err_count_d;
  logic [OW-1:0] max_occ_q, max_occ_d;
  logic [1:0]    err_inc;
  logic [8:0]    err_sum;

  // Both error kinds can fire on one sample (a dropped sym_start), so they add.
  always_comb begin : status_next
    err_inc     = {1'b0, drop} + {1'b0, sync_d};
    err_sum     = {1'b0, err_count_q} + {7'b0, err_inc};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
    max_occ_d   = (occ_d > max_occ_q) ? occ_d : max_occ_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_count_q <= '0;
      max_occ_q   <= '0;
    end else begin
      err_count_q <= err_count_d;
      max_occ_q   <= max_occ_d;
    end
  end

  assign err_count = err_count_q;
  assign max_occ   = max_occ_q;
`endif

endmodule
